// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side signal bundle for mem_arbiter.
// slave = the arbiter; master = requesters plus memory/bus environment.
interface mem_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 16,
  parameter int AW      = 8
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    req_we;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_wdata;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    ack;
  logic [DW-1:0]         rdata;
  logic                  busy;
  logic                  mem_re;
  logic                  mem_we;
  logic                  mem_drive;
  logic [AW-1:0]         mem_addr;
  logic [DW-1:0]         mem_wdata;
  logic [DW-1:0]         mem_rdata;

  modport slave (
    input  req, req_we, req_addr, req_wdata, mem_rdata,
    output gnt, ack, rdata, busy, mem_re, mem_we, mem_drive, mem_addr, mem_wdata
  );

  modport master (
    output req, req_we, req_addr, req_wdata, mem_rdata,
    input  gnt, ack, rdata, busy, mem_re, mem_we, mem_drive, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port memory among NUM_REQ requesters.
// All outputs decode from registered state/sel/op; nothing follows req combinationally.
module mem_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 16,
  parameter int AW      = 8
) (
  input logic          clock,
  input logic          preset_L,
  mem_arbiter_if.slave bus
);
  localparam int          PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NR = NUM_REQ;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nx;

  logic [PW-1:0]      ptr, ptr_nx, sel, winner;
  logic               op, found;
  int unsigned        idx;
  logic [AW-1:0]      addr_q;
  logic [DW-1:0]      wdata_q, rdata_q;
  logic [AW-1:0]      addr_a  [NUM_REQ];
  logic [DW-1:0]      wdata_a [NUM_REQ];
  logic [NUM_REQ-1:0] gnt, ack;
  logic               mem_re, mem_we, mem_drive;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g]  = bus.req_addr[g*AW +: AW];
    assign wdata_a[g] = bus.req_wdata[g*DW +: DW];
  end

  // Search ptr, ptr+1, ... wrapping; first requester found wins.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    idx    = 0;
    for (int unsigned k = 0; k < NR; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NR) idx = idx - NR;
      if (!found && bus.req[PW'(idx)]) begin
        found  = 1'b1;
        winner = PW'(idx);
      end
    end
    ptr_nx = (winner == PW'(NR - 1)) ? '0 : winner + PW'(1);
  end

  always_ff @(posedge clock or negedge preset_L) begin
    if (!preset_L) state <= IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (found) state_nx = ACCESS;
      ACCESS:  state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge preset_L) begin
    if (!preset_L) begin
      ptr     <= '0;
      sel     <= '0;
      op      <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state == IDLE && found) begin
        sel     <= winner;
        op      <= bus.req_we[winner];
        addr_q  <= addr_a[winner];
        wdata_q <= wdata_a[winner];
        ptr     <= ptr_nx;
      end
      if (state == ACCESS && !op) rdata_q <= bus.mem_rdata;
    end
  end

  always_comb begin
    gnt       = '0;
    ack       = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_drive = 1'b0;
    case (state)
      ACCESS: begin
        gnt[sel]  = 1'b1;
        mem_re    = !op;
        mem_we    = op;
        mem_drive = op;
      end
      RESP: begin
        gnt[sel] = 1'b1;
        ack[sel] = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.gnt       = gnt;
  assign bus.ack       = ack;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = (state != IDLE);
  assign bus.mem_re    = mem_re;
  assign bus.mem_we    = mem_we;
  assign bus.mem_drive = mem_drive;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter against a round-robin transaction model.
module tb_mem_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 8;

  logic clock;
  logic preset_L;
  int   vectors;
  int   miscompares;

  logic [DW-1:0] mem   [256];
  logic [DW-1:0] mem_m [256];
  int            ptr_m;
  logic [DW-1:0] rdata_m;
  int            w_obs;

  mem_arbiter_if #(.NUM_REQ(N), .DW(DW), .AW(AW)) bus ();

  mem_arbiter #(.NUM_REQ(N), .DW(DW), .AW(AW)) dut (
    .clock    (clock),
    .preset_L (preset_L),
    .bus      (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Environment memory: drives the shared bus on reads, absorbs writes.
  assign bus.mem_rdata = bus.mem_re ? mem[bus.mem_addr] : '0;
  always @(posedge clock) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req[i]              = 1'b1;
    bus.req_we[i]           = we;
    bus.req_addr[i*AW +: AW]  = a;
    bus.req_wdata[i*DW +: DW] = d;
  endtask

  // One full grant: IDLE (now) -> ACCESS -> RESP -> IDLE, checking every cycle.
  task automatic run_grant(output int wo);
    int            w;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    w  = rr_pick(bus.req, ptr_m);
    we = bus.req_we[w];
    a  = bus.req_addr[w*AW +: AW];
    d  = bus.req_wdata[w*DW +: DW];
    tick;
    wo = -1;
    for (int i = 0; i < N; i++) if (bus.gnt[i]) wo = i;
    check("acc_gnt",   64'(bus.gnt), 64'(1) << w);
    check("acc_ack",   64'(bus.ack), 0);
    check("acc_re",    64'(bus.mem_re), 64'(!we));
    check("acc_we",    64'(bus.mem_we), 64'(we));
    check("acc_drive", 64'(bus.mem_drive), 64'(we));
    check("acc_addr",  64'(bus.mem_addr), 64'(a));
    check("acc_busy",  64'(bus.busy), 1);
    if (we) check("acc_wdata", 64'(bus.mem_wdata), 64'(d));
    bus.req_addr[w*AW +: AW]  = ~a;
    bus.req_wdata[w*DW +: DW] = ~d;
    tick;
    if (we) mem_m[a] = d;
    else    rdata_m  = mem_m[a];
    ptr_m = (w + 1) % N;
    check("resp_ack",  64'(bus.ack), 64'(1) << w);
    check("resp_gnt",  64'(bus.gnt), 64'(1) << w);
    check("resp_en",   64'({bus.mem_re, bus.mem_we, bus.mem_drive}), 0);
    check("resp_addr", 64'(bus.mem_addr), 64'(a));
    check("resp_rdata", 64'(bus.rdata), 64'(rdata_m));
    bus.req[w] = 1'b0;
    tick;
    check("idle_busy",  64'(bus.busy), 0);
    check("idle_ack",   64'(bus.ack), 0);
    check("idle_gnt",   64'(bus.gnt), 0);
    check("idle_rdata", 64'(bus.rdata), 64'(rdata_m));
  endtask

  always @(negedge clock) begin
    if (preset_L) begin
      check("inv_re_drive", 64'(bus.mem_re & bus.mem_drive), 0);
      check("inv_re_we",    64'(bus.mem_re & bus.mem_we), 0);
      check("inv_gnt_oh",   64'($onehot0(bus.gnt)), 1);
      check("inv_ack_oh",   64'($onehot0(bus.ack)), 1);
      check("inv_ack_gnt",  64'(bus.ack & ~bus.gnt), 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    preset_L    = 1'b0;
    bus.req       = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i]   = DW'($urandom);
      mem_m[i] = mem[i];
    end
    mem[8'h3C]   = 16'hBEEF;
    mem_m[8'h3C] = 16'hBEEF;
    ptr_m   = 0;
    rdata_m = '0;

    tick;
    tick;
    check("rst_outs", 64'({bus.gnt, bus.ack, bus.busy, bus.mem_re, bus.mem_we, bus.mem_drive}), 0);
    check("rst_addr",  64'(bus.mem_addr), 0);
    check("rst_wdata", 64'(bus.mem_wdata), 0);
    check("rst_rdata", 64'(bus.rdata), 0);
    preset_L = 1'b1;
    tick;
    check("idle_busy0", 64'(bus.busy), 0);

    // Read of 3C by requester 1.
    set_req(1, 1'b0, 8'h3C, 16'h0);
    run_grant(w_obs);
    check("rd_winner", 64'(w_obs), 1);
    check("rd_beef", 64'(bus.rdata), 64'(16'hBEEF));

    // Write 1234 to 05 by requester 2, read back by requester 3 (ptr wraps to 0).
    set_req(2, 1'b1, 8'h05, 16'h1234);
    run_grant(w_obs);
    check("wr_winner", 64'(w_obs), 2);
    check("wr_rdata_hold", 64'(bus.rdata), 64'(16'hBEEF));
    set_req(3, 1'b0, 8'h05, 16'h0);
    run_grant(w_obs);
    check("rb_1234", 64'(bus.rdata), 64'(16'h1234));

    // All four request: order 0,1,2,3 twice.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(8'h10 + i), '0);
      for (int k = 0; k < N; k++) begin
        run_grant(w_obs);
        check("rr_order", 64'(w_obs), 64'(k));
      end
    end

    // ptr=2 after serving requester 1; then 0 beats 1.
    set_req(1, 1'b0, 8'h20, '0);
    run_grant(w_obs);
    set_req(0, 1'b1, 8'h21, 16'hA5A5);
    set_req(1, 1'b0, 8'h21, '0);
    run_grant(w_obs);
    check("wrap_first", 64'(w_obs), 0);
    run_grant(w_obs);
    check("wrap_second", 64'(w_obs), 1);
    check("wrap_rdata", 64'(bus.rdata), 64'(16'hA5A5));

    // Reset during ACCESS of a write.
    set_req(2, 1'b1, 8'h30, 16'hDEAD);
    tick;
    check("pre_rst_we", 64'(bus.mem_we), 1);
    preset_L = 1'b0;
    bus.req  = '0;
    #1;
    check("abort_outs", 64'({bus.gnt, bus.ack, bus.busy, bus.mem_re, bus.mem_we, bus.mem_drive}), 0);
    check("abort_rdata", 64'(bus.rdata), 0);
    tick;
    check("abort_no_ack", 64'(bus.ack), 0);
    preset_L = 1'b1;
    ptr_m    = 0;
    rdata_m  = '0;
    tick;
    check("abort_nowrite", 64'(mem[8'h30]), 64'(mem_m[8'h30]));
    set_req(1, 1'b0, 8'h3C, '0);
    set_req(3, 1'b0, 8'h05, '0);
    run_grant(w_obs);
    check("post_rst_winner", 64'(w_obs), 1);
    run_grant(w_obs);
    check("post_rst_next", 64'(w_obs), 3);

    // Random traffic over a small address window so reads hit earlier writes.
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < N; i++)
        if (!bus.req[i] && $urandom_range(1, 0) == 1)
          set_req(i, 1'($urandom), AW'($urandom_range(15, 0)), DW'($urandom));
      if (bus.req == '0)
        set_req($urandom_range(N - 1, 0), 1'($urandom), AW'($urandom_range(15, 0)), DW'($urandom));
      run_grant(w_obs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
